// File: rtl/ps2_keymap_if.sv
// Scan-code byte stream in, Hack KBD word out, between the PS/2 receiver
// and the keyboard register.
interface ps2_keymap_if;
    logic [7:0]  iCODE;
    logic        iSTB;
    logic [15:0] oKEY;
    logic        oPRESS;
    logic        oCAPS;

    modport master (output iCODE, iSTB, input oKEY, oPRESS, oCAPS);
    modport slave  (input iCODE, iSTB, output oKEY, oPRESS, oCAPS);
endinterface

// File: rtl/ps2_keymap.sv
// PS/2 set-2 scan-code decoder feeding the Hack KBD register: tracks E0/F0/E1
// prefixes, shift and caps-lock, and holds the code of the currently pressed key.
module ps2_keymap #(
    parameter int PAUSE_SKIP = 7
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    ps2_keymap_if.slave  kbd
);

    localparam int CNT_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_e;

    // lo/hi are the unshifted/shifted values; lo == 0 means unmapped
    typedef struct packed {
        logic       letter;
        logic [7:0] lo;
        logic [7:0] hi;
    } map_t;

    function automatic map_t map_code(input logic [7:0] code, input logic ext);
        map_t m;
        m = '0;
        if (ext) begin
            case (code)
                8'h6B:   m.lo = 8'd130;
                8'h75:   m.lo = 8'd131;
                8'h74:   m.lo = 8'd132;
                8'h72:   m.lo = 8'd133;
                8'h6C:   m.lo = 8'd134;
                8'h69:   m.lo = 8'd135;
                8'h7D:   m.lo = 8'd136;
                8'h7A:   m.lo = 8'd137;
                8'h70:   m.lo = 8'd138;
                8'h71:   m.lo = 8'd139;
                8'h5A:   m.lo = 8'd128;
                default: m.lo = 8'd0;
            endcase
            m.hi = m.lo;
        end else begin
            case (code)
                8'h1C: m.lo = 8'd97;
                8'h32: m.lo = 8'd98;
                8'h21: m.lo = 8'd99;
                8'h23: m.lo = 8'd100;
                8'h24: m.lo = 8'd101;
                8'h2B: m.lo = 8'd102;
                8'h34: m.lo = 8'd103;
                8'h33: m.lo = 8'd104;
                8'h43: m.lo = 8'd105;
                8'h3B: m.lo = 8'd106;
                8'h42: m.lo = 8'd107;
                8'h4B: m.lo = 8'd108;
                8'h3A: m.lo = 8'd109;
                8'h31: m.lo = 8'd110;
                8'h44: m.lo = 8'd111;
                8'h4D: m.lo = 8'd112;
                8'h15: m.lo = 8'd113;
                8'h2D: m.lo = 8'd114;
                8'h1B: m.lo = 8'd115;
                8'h2C: m.lo = 8'd116;
                8'h3C: m.lo = 8'd117;
                8'h2A: m.lo = 8'd118;
                8'h1D: m.lo = 8'd119;
                8'h22: m.lo = 8'd120;
                8'h35: m.lo = 8'd121;
                8'h1A: m.lo = 8'd122;
                8'h45: begin m.lo = 8'd48; m.hi = 8'd41;  end
                8'h16: begin m.lo = 8'd49; m.hi = 8'd33;  end
                8'h1E: begin m.lo = 8'd50; m.hi = 8'd64;  end
                8'h26: begin m.lo = 8'd51; m.hi = 8'd35;  end
                8'h25: begin m.lo = 8'd52; m.hi = 8'd36;  end
                8'h2E: begin m.lo = 8'd53; m.hi = 8'd37;  end
                8'h36: begin m.lo = 8'd54; m.hi = 8'd94;  end
                8'h3D: begin m.lo = 8'd55; m.hi = 8'd38;  end
                8'h3E: begin m.lo = 8'd56; m.hi = 8'd42;  end
                8'h46: begin m.lo = 8'd57; m.hi = 8'd40;  end
                8'h4E: begin m.lo = 8'd45; m.hi = 8'd95;  end
                8'h55: begin m.lo = 8'd61; m.hi = 8'd43;  end
                8'h54: begin m.lo = 8'd91; m.hi = 8'd123; end
                8'h5B: begin m.lo = 8'd93; m.hi = 8'd125; end
                8'h4C: begin m.lo = 8'd59; m.hi = 8'd58;  end
                8'h52: begin m.lo = 8'd39; m.hi = 8'd34;  end
                8'h41: begin m.lo = 8'd44; m.hi = 8'd60;  end
                8'h49: begin m.lo = 8'd46; m.hi = 8'd62;  end
                8'h4A: begin m.lo = 8'd47; m.hi = 8'd63;  end
                8'h0E: begin m.lo = 8'd96; m.hi = 8'd126; end
                8'h5D: begin m.lo = 8'd92; m.hi = 8'd124; end
                8'h29: m.lo = 8'd32;
                8'h0D: m.lo = 8'd9;
                8'h5A: m.lo = 8'd128;
                8'h66: m.lo = 8'd129;
                8'h76: m.lo = 8'd140;
                8'h05: m.lo = 8'd141;
                8'h06: m.lo = 8'd142;
                8'h04: m.lo = 8'd143;
                8'h0C: m.lo = 8'd144;
                8'h03: m.lo = 8'd145;
                8'h0B: m.lo = 8'd146;
                8'h83: m.lo = 8'd147;
                8'h0A: m.lo = 8'd148;
                8'h01: m.lo = 8'd149;
                8'h09: m.lo = 8'd150;
                8'h78: m.lo = 8'd151;
                8'h07: m.lo = 8'd152;
                default: m.lo = 8'd0;
            endcase
            // Letters are the only entries in 97..122, so the range identifies them
            m.letter = (m.lo >= 8'd97) && (m.lo <= 8'd122);
            if (m.letter) begin
                m.hi = m.lo - 8'd32;
            end else if (m.hi == 8'd0) begin
                m.hi = m.lo;
            end
        end
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lshift_q, lshift_d;
    logic               rshift_q, rshift_d;
    logic               caps_q, caps_d;
    logic [7:0]         key_q, key_d;
    logic               press_q, press_d;

    logic               do_make;
    logic               do_break;
    logic               ext;
    logic               upper;
    logic               mapped;
    logic               held_match;
    logic [7:0]         map_val;
    map_t               map_cur;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
            key_q    <= 8'd0;
            press_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
            key_q    <= key_d;
            press_q  <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kbd.iSTB) begin
            case (state_q)
                ST_IDLE: begin
                    if (kbd.iCODE == PFX_EXT) begin
                        state_d = ST_EXT;
                    end else if (kbd.iCODE == PFX_BRK) begin
                        state_d = ST_BRK;
                    end else if (kbd.iCODE == PFX_PAUSE && PAUSE_SKIP > 0) begin
                        state_d = ST_SKIP;
                        cnt_d   = CNT_W'(PAUSE_SKIP);
                    end
                end
                ST_EXT:     state_d = (kbd.iCODE == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                ST_SKIP: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        do_make  = 1'b0;
        do_break = 1'b0;
        ext      = 1'b0;
        if (kbd.iSTB) begin
            case (state_q)
                ST_IDLE: do_make = (kbd.iCODE != PFX_EXT) && (kbd.iCODE != PFX_BRK)
                                   && (kbd.iCODE != PFX_PAUSE);
                ST_EXT: begin
                    ext     = 1'b1;
                    do_make = (kbd.iCODE != PFX_BRK);
                end
                ST_BRK:  do_break = 1'b1;
                ST_EXT_BRK: begin
                    ext      = 1'b1;
                    do_break = 1'b1;
                end
                default: ;
            endcase
        end

        map_cur = map_code(kbd.iCODE, ext);
        mapped  = (map_cur.lo != 8'd0);
        upper   = map_cur.letter ? ((lshift_q | rshift_q) ^ caps_q) : (lshift_q | rshift_q);
        map_val = upper ? map_cur.hi : map_cur.lo;
        // A letter break clears the held key whichever case it was pressed in
        held_match = mapped && (map_cur.letter ? ((key_q == map_cur.lo) || (key_q == map_cur.hi))
                                               : (key_q == map_val));

        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        key_d    = key_q;
        press_d  = 1'b0;

        if (do_make) begin
            if (!ext && kbd.iCODE == SC_LSHIFT) begin
                lshift_d = 1'b1;
            end else if (!ext && kbd.iCODE == SC_RSHIFT) begin
                rshift_d = 1'b1;
            end else if (!ext && kbd.iCODE == SC_CAPS) begin
                caps_d = ~caps_q;
            end else if (mapped) begin
                key_d   = map_val;
                press_d = 1'b1;
            end
        end else if (do_break) begin
            if (!ext && kbd.iCODE == SC_LSHIFT) begin
                lshift_d = 1'b0;
            end else if (!ext && kbd.iCODE == SC_RSHIFT) begin
                rshift_d = 1'b0;
            end else if (held_match) begin
                key_d = 8'd0;
            end
        end
    end

    assign kbd.oKEY   = {8'h00, key_q};
    assign kbd.oPRESS = press_q;
    assign kbd.oCAPS  = caps_q;

endmodule

// File: tb/tb_ps2_keymap.sv
// Testbench for ps2_keymap: fixed vector table, hand-built multi-byte corner
// sequences, then random byte streams checked against a lookup-table model.
module tb_ps2_keymap;

    localparam int PAUSE_SKIP = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ps2_keymap_if kbd ();

    ps2_keymap #(.PAUSE_SKIP(PAUSE_SKIP)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .kbd    (kbd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  code;
        logic [15:0] key;
        logic        press;
        logic        caps;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: pending prefixes as plain flags plus a skip count
    int m_lo[256];
    int m_hi[256];
    bit m_let[256];
    int m_ext_map[256];
    bit m_ext, m_brk, m_ls, m_rs, m_caps, m_press;
    int m_skip, m_key;

    task automatic checkOutput(input string name, input logic [15:0] ek, input logic ep, input logic ec);
        total++;
        if (kbd.oKEY !== ek || kbd.oPRESS !== ep || kbd.oCAPS !== ec) begin
            bad++;
            $display("[TB] FAIL %s: got key=%0d press=%0b caps=%0b, want key=%0d press=%0b caps=%0b",
                     name, kbd.oKEY, kbd.oPRESS, kbd.oCAPS, ek, ep, ec);
        end
    endtask

    // Presents one byte for one cycle; returns at the following negedge
    task automatic applyStimulus(input logic [7:0] code);
        kbd.iCODE = code;
        kbd.iSTB  = 1'b1;
        @(negedge clk);
        kbd.iSTB  = 1'b0;
    endtask

    task automatic doReset();
        kbd.iSTB = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic addVec(input logic [7:0] c, input int k, input logic p, input logic cp);
        vec_t v;
        v.code = c; v.key = 16'(k); v.press = p; v.caps = cp;
        vecs.push_back(v);
    endtask

    task automatic buildMaps();
        logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] pc[11] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E, 8'h5D};
        logic [7:0] fc[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
        logic [7:0] ec[11] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71, 8'h5A};
        logic [7:0] xc[5]  = '{8'h29, 8'h0D, 8'h5A, 8'h66, 8'h76};
        int         xv[5]  = '{32, 9, 128, 129, 140};
        string dsh = ")!@#$%^&*(";
        int plo[11] = '{45, 61, 91, 93, 59, 39, 44, 46, 47, 96, 92};
        int phi[11] = '{95, 43, 123, 125, 58, 34, 60, 62, 63, 126, 124};
        for (int i = 0; i < 256; i++) begin
            m_lo[i] = 0; m_hi[i] = 0; m_let[i] = 0; m_ext_map[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            m_lo[lc[i]] = 97 + i; m_hi[lc[i]] = 65 + i; m_let[lc[i]] = 1;
        end
        for (int i = 0; i < 10; i++) begin
            m_lo[dc[i]] = 48 + i; m_hi[dc[i]] = int'(dsh[i]);
        end
        for (int i = 0; i < 11; i++) begin
            m_lo[pc[i]] = plo[i]; m_hi[pc[i]] = phi[i];
        end
        for (int i = 0; i < 12; i++) begin
            m_lo[fc[i]] = 141 + i; m_hi[fc[i]] = 141 + i;
        end
        for (int i = 0; i < 5; i++) begin
            m_lo[xc[i]] = xv[i]; m_hi[xc[i]] = xv[i];
        end
        for (int i = 0; i < 11; i++) begin
            m_ext_map[ec[i]] = (i < 10) ? 130 + i : 128;
        end
    endtask

    function automatic int modelValue(input int c, input bit ext);
        bit up;
        if (ext) return m_ext_map[c];
        up = m_let[c] ? ((m_ls | m_rs) ^ m_caps) : (m_ls | m_rs);
        return up ? m_hi[c] : m_lo[c];
    endfunction

    task automatic modelReset();
        m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_caps = 0;
        m_press = 0; m_skip = 0; m_key = 0;
    endtask

    task automatic modelByte(input int c);
        int v;
        m_press = 0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk) begin
            v = modelValue(c, m_ext);
            if (!m_ext && c == 'h12) m_ls = 0;
            else if (!m_ext && c == 'h59) m_rs = 0;
            else if (v != 0 && (m_key == v || (!m_ext && m_let[c] && (m_key == m_lo[c] || m_key == m_hi[c]))))
                m_key = 0;
            m_brk = 0; m_ext = 0;
        end else if (m_ext) begin
            if (c == 'hF0) m_brk = 1;
            else begin
                v = modelValue(c, 1);
                if (v != 0) begin m_key = v; m_press = 1; end
                m_ext = 0;
            end
        end else if (c == 'hE0) m_ext = 1;
        else if (c == 'hF0) m_brk = 1;
        else if (c == 'hE1) m_skip = PAUSE_SKIP;
        else if (c == 'h12) m_ls = 1;
        else if (c == 'h59) m_rs = 1;
        else if (c == 'h58) m_caps = ~m_caps;
        else begin
            v = modelValue(c, 0);
            if (v != 0) begin m_key = v; m_press = 1; end
        end
    endtask

    function automatic logic [7:0] pickByte();
        logic [7:0] pool[16] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h4E, 8'h5D, 8'h75, 8'h6B,
                                 8'h5A, 8'h05, 8'h83, 8'h29, 8'h7C, 8'h71, 8'h45, 8'h0E};
        int r = $urandom_range(0, 99);
        if (r < 22) return 8'hF0;
        if (r < 32) return 8'hE0;
        if (r < 34) return 8'hE1;
        if (r < 39) return (r < 37) ? 8'h12 : 8'h59;
        if (r < 42) return 8'h58;
        if (r < 48) return 8'($urandom_range(0, 255));
        return pool[$urandom_range(0, 15)];
    endfunction

    initial begin
        kbd.iSTB  = 1'b0;
        kbd.iCODE = 8'h00;
        buildMaps();

        // Table: letters, shift, extended keys, caps and repeat, newer press, symbols
        addVec(8'h1C, 97, 1, 0);  addVec(8'hF0, 97, 0, 0);  addVec(8'h1C, 0, 0, 0);
        addVec(8'h12, 0, 0, 0);   addVec(8'h1C, 65, 1, 0);  addVec(8'hF0, 65, 0, 0);
        addVec(8'h12, 65, 0, 0);  addVec(8'hF0, 65, 0, 0);  addVec(8'h1C, 0, 0, 0);
        addVec(8'hE0, 0, 0, 0);   addVec(8'h75, 131, 1, 0); addVec(8'hE0, 131, 0, 0);
        addVec(8'hF0, 131, 0, 0); addVec(8'h75, 0, 0, 0);   addVec(8'h75, 0, 0, 0);
        addVec(8'h58, 0, 0, 1);   addVec(8'hF0, 0, 0, 1);   addVec(8'h58, 0, 0, 1);
        addVec(8'h1C, 65, 1, 1);  addVec(8'h1C, 65, 1, 1);  addVec(8'h1C, 65, 1, 1);
        addVec(8'h1C, 65, 1, 1);  addVec(8'hF0, 65, 0, 1);  addVec(8'h1C, 0, 0, 1);
        addVec(8'h12, 0, 0, 1);   addVec(8'h1C, 97, 1, 1);  addVec(8'hF0, 97, 0, 1);
        addVec(8'h12, 97, 0, 1);  addVec(8'hF0, 97, 0, 1);  addVec(8'h1C, 0, 0, 1);
        addVec(8'h45, 48, 1, 1);  addVec(8'hF0, 48, 0, 1);  addVec(8'h45, 0, 0, 1);
        addVec(8'h58, 0, 0, 0);   addVec(8'hF0, 0, 0, 0);   addVec(8'h58, 0, 0, 0);
        addVec(8'h1C, 97, 1, 0);  addVec(8'h32, 98, 1, 0);  addVec(8'hF0, 98, 0, 0);
        addVec(8'h1C, 98, 0, 0);  addVec(8'hF0, 98, 0, 0);  addVec(8'h32, 0, 0, 0);
        addVec(8'h59, 0, 0, 0);   addVec(8'h16, 33, 1, 0);  addVec(8'hF0, 33, 0, 0);
        addVec(8'h16, 0, 0, 0);   addVec(8'h4E, 95, 1, 0);  addVec(8'hF0, 95, 0, 0);
        addVec(8'h59, 95, 0, 0);  addVec(8'h05, 141, 1, 0); addVec(8'h07, 152, 1, 0);
        addVec(8'h83, 147, 1, 0); addVec(8'hF0, 147, 0, 0); addVec(8'h83, 0, 0, 0);
        addVec(8'hE0, 0, 0, 0);   addVec(8'h12, 0, 0, 0);   addVec(8'hE0, 0, 0, 0);
        addVec(8'h7C, 0, 0, 0);   addVec(8'hE0, 0, 0, 0);   addVec(8'h5A, 128, 1, 0);
        addVec(8'hE0, 128, 0, 0); addVec(8'hF0, 128, 0, 0); addVec(8'h5A, 0, 0, 0);
        addVec(8'h76, 140, 1, 0); addVec(8'hF0, 140, 0, 0); addVec(8'h76, 0, 0, 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset held", 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset released", 16'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].code);
            checkOutput($sformatf("vec%0d", i), vecs[i].key, vecs[i].press, vecs[i].caps);
        end

        // Pause sequence: seven trailing bytes must be dropped, then decoding resumes
        begin
            logic [7:0] pause_seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            doReset();
            for (int i = 0; i < 8; i++) begin
                applyStimulus(pause_seq[i]);
                checkOutput($sformatf("pause%0d", i), 16'd0, 1'b0, 1'b0);
            end
            applyStimulus(8'h1C);
            checkOutput("after pause", 16'd97, 1'b1, 1'b0);
            applyStimulus(8'hE1);
            checkOutput("pause2 prefix", 16'd97, 1'b0, 1'b0);
            for (int i = 0; i < PAUSE_SKIP; i++) begin
                applyStimulus(8'h1C);
                checkOutput($sformatf("pause2 skip%0d", i), 16'd97, 1'b0, 1'b0);
            end
            applyStimulus(8'hF0);
            checkOutput("pause2 brk", 16'd97, 1'b0, 1'b0);
            applyStimulus(8'h1C);
            checkOutput("pause2 release", 16'd0, 1'b0, 1'b0);
        end

        // Reset between E0 and its code byte discards the prefix
        applyStimulus(8'h58);
        checkOutput("pre-rst caps", 16'd0, 1'b0, 1'b1);
        applyStimulus(8'h1C);
        checkOutput("pre-rst key", 16'd65, 1'b1, 1'b1);
        applyStimulus(8'hE0);
        checkOutput("pre-rst E0", 16'd65, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("mid reset", 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h75);
        checkOutput("post-rst 75", 16'd0, 1'b0, 1'b0);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        checkOutput("post-rst E0 75", 16'd131, 1'b1, 1'b0);

        // Random streams with idle gaps and back-to-back strobes against the model
        doReset();
        modelReset();
        for (int n = 0; n < 800; n++) begin
            logic [7:0] c;
            int gap;
            c = pickByte();
            modelByte(int'(c));
            applyStimulus(c);
            checkOutput($sformatf("rand%0d code=%02h", n, c), 16'(m_key), m_press, m_caps);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkOutput($sformatf("rand%0d idle", n), 16'(m_key), 1'b0, m_caps);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
